// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: Moore sequencer plus ALU decoder.
// Drives datapath mux selects and write enables from the current state.
module mc_ctrl_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               iord,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic               memtoreg,
  output logic               regdst,
  output logic               irwrite,
  output logic               memwrite,
  output logic               regwrite,
  output logic               pcen,
  output logic [2:0]         alucontrol,
  output logic               illegal,
  output logic [STATE_W-1:0] dbg_state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    AL_NONE,
    AL_ADD,
    AL_SUB,
    AL_FN
  } aluop_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t state;
  state_t nxt;
  aluop_t aluop;
  logic   pcwrite;
  logic   branch;
  logic   bad_op;
  logic   bad_fn;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= nxt;
  end

  always_comb begin
    nxt      = FETCH;
    aluop    = AL_NONE;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    bad_op   = 1'b0;
    iord     = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    case (state)
      FETCH: begin
        alusrcb = 2'b01;
        aluop   = AL_ADD;
        irwrite = 1'b1;
        pcwrite = 1'b1;
        nxt     = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        aluop   = AL_ADD;
        case (op)
          OP_LW,
          OP_SW:   nxt = MEMADR;
          OP_RTYP: nxt = EXEC;
          OP_BEQ:  nxt = BRANCH;
          OP_ADDI: nxt = ADDIEX;
          OP_J:    nxt = JUMP;
          default: bad_op = 1'b1;
        endcase
      end
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = AL_ADD;
        if (state == ADDIEX) nxt = ADDIWB;
        else if (op == OP_LW) nxt = MEMRD;
        else nxt = MEMWR;
      end
      MEMRD: begin
        iord = 1'b1;
        nxt  = MEMWB;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      EXEC: begin
        alusrca = 1'b1;
        aluop   = AL_FN;
        nxt     = ALUWB;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = AL_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIWB: regwrite = 1'b1;
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: nxt = FETCH;
    endcase

    bad_fn     = 1'b0;
    alucontrol = 3'b000;
    unique case (aluop)
      AL_NONE: alucontrol = 3'b000;
      AL_ADD:  alucontrol = 3'b010;
      AL_SUB:  alucontrol = 3'b110;
      AL_FN: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default: begin
            alucontrol = 3'b010;
            bad_fn     = 1'b1;
          end
        endcase
      end
    endcase

    pcen      = pcwrite | (branch & zero);
    illegal   = bad_op | bad_fn;
    dbg_state = STATE_W'(state);

    // Reset masks everything so a mid-instruction reset writes nothing.
    if (reset) begin
      iord       = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      irwrite    = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      pcen       = 1'b0;
      alucontrol = 3'b000;
      illegal    = 1'b0;
      dbg_state  = '0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed table-driven bench for mc_ctrl_fsm.
// Each row drives inputs, checks state and outputs, then clocks.
module tb_mc_ctrl_fsm;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord, alusrca, memtoreg, regdst;
  logic       irwrite, memwrite, regwrite, pcen, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] dbg_state;

  mc_ctrl_fsm #(.STATE_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .iord       (iord),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .irwrite    (irwrite),
    .memwrite   (memwrite),
    .regwrite   (regwrite),
    .pcen       (pcen),
    .alucontrol (alucontrol),
    .illegal    (illegal),
    .dbg_state  (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic [3:0]  st;
    logic [15:0] exp;
    logic [15:0] msk;
  } vec_t;

  // {iord,alusrca,alusrcb,pcsrc,memtoreg,regdst,
  //  irwrite,memwrite,regwrite,pcen,alucontrol,illegal}
  localparam logic [15:0] E_RST    = 16'h0000;
  localparam logic [15:0] E_FETCH  = 16'h1094;
  localparam logic [15:0] E_DEC    = 16'h3004;
  localparam logic [15:0] E_DECILL = 16'h3005;
  localparam logic [15:0] E_MADR   = 16'h6004;
  localparam logic [15:0] E_MRD    = 16'h8000;
  localparam logic [15:0] E_MWB    = 16'h0220;
  localparam logic [15:0] E_MWR    = 16'h8040;
  localparam logic [15:0] E_EXSLT  = 16'h400E;
  localparam logic [15:0] E_EXADD  = 16'h4004;
  localparam logic [15:0] E_EXILL  = 16'h4005;
  localparam logic [15:0] E_AWB    = 16'h0120;
  localparam logic [15:0] E_BRZ1   = 16'h441C;
  localparam logic [15:0] E_BRZ0   = 16'h440C;
  localparam logic [15:0] E_AIWB   = 16'h0020;
  localparam logic [15:0] E_JMP    = 16'h0810;
  localparam logic [15:0] M_ALL    = 16'hFFFF;
  localparam logic [15:0] M_NOAL   = 16'hFFF1;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  vec_t vq[$];
  int   checks;
  int   errors;

  task automatic add(input logic r, input logic [5:0] o,
                     input logic [5:0] f, input logic z,
                     input logic [3:0] s, input logic [15:0] e,
                     input logic [15:0] m);
    vec_t v;
    v.rst = r; v.op = o; v.fn = f; v.z = z;
    v.st = s; v.exp = e; v.msk = m;
    vq.push_back(v);
  endtask

  function automatic logic [15:0] outs();
    return {iord, alusrca, alusrcb, pcsrc, memtoreg, regdst,
            irwrite, memwrite, regwrite, pcen, alucontrol, illegal};
  endfunction

  task automatic chk(input string nm, input logic [3:0] st,
                     input logic [15:0] e, input logic [15:0] m);
    logic [15:0] g;
    g = outs();
    checks++;
    if (dbg_state !== st) begin
      errors++;
      $display("FAIL %s state: got %0d want %0d", nm, dbg_state, st);
    end
    checks++;
    if (((g ^ e) & m) !== 16'h0) begin
      errors++;
      $display("FAIL %s outs: got %h want %h mask %h", nm, g, e, m);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; op = RT; funct = 6'b100000; zero = 1'b0;

    add(1, RT, 6'b100000, 0, 4'd0, E_RST, M_ALL);
    add(1, RT, 6'b100000, 0, 4'd0, E_RST, M_ALL);
    // lw
    add(0, LW, 6'b0, 0, 4'd0, E_FETCH, M_ALL);
    add(0, LW, 6'b0, 0, 4'd1, E_DEC, M_ALL);
    add(0, LW, 6'b0, 0, 4'd2, E_MADR, M_ALL);
    add(0, LW, 6'b0, 0, 4'd3, E_MRD, M_NOAL);
    add(0, LW, 6'b0, 0, 4'd4, E_MWB, M_NOAL);
    // R-type slt
    add(0, RT, 6'b101010, 0, 4'd0, E_FETCH, M_ALL);
    add(0, RT, 6'b101010, 0, 4'd1, E_DEC, M_ALL);
    add(0, RT, 6'b101010, 0, 4'd6, E_EXSLT, M_ALL);
    add(0, RT, 6'b101010, 0, 4'd7, E_AWB, M_NOAL);
    // beq taken, then not taken
    add(0, BEQ, 6'b0, 1, 4'd0, E_FETCH, M_ALL);
    add(0, BEQ, 6'b0, 1, 4'd1, E_DEC, M_ALL);
    add(0, BEQ, 6'b0, 1, 4'd8, E_BRZ1, M_ALL);
    add(0, BEQ, 6'b0, 0, 4'd0, E_FETCH, M_ALL);
    add(0, BEQ, 6'b0, 0, 4'd1, E_DEC, M_ALL);
    add(0, BEQ, 6'b0, 0, 4'd8, E_BRZ0, M_ALL);
    // sw, j, addi
    add(0, SW, 6'b0, 0, 4'd0, E_FETCH, M_ALL);
    add(0, SW, 6'b0, 0, 4'd1, E_DEC, M_ALL);
    add(0, SW, 6'b0, 0, 4'd2, E_MADR, M_ALL);
    add(0, SW, 6'b0, 0, 4'd5, E_MWR, M_NOAL);
    add(0, JMP, 6'b0, 0, 4'd0, E_FETCH, M_ALL);
    add(0, JMP, 6'b0, 0, 4'd1, E_DEC, M_ALL);
    add(0, JMP, 6'b0, 0, 4'd11, E_JMP, M_NOAL);
    add(0, ADDI, 6'b0, 0, 4'd0, E_FETCH, M_ALL);
    add(0, ADDI, 6'b0, 0, 4'd1, E_DEC, M_ALL);
    add(0, ADDI, 6'b0, 0, 4'd9, E_MADR, M_ALL);
    add(0, ADDI, 6'b0, 0, 4'd10, E_AIWB, M_NOAL);
    // illegal op
    add(0, BAD, 6'b0, 0, 4'd0, E_FETCH, M_ALL);
    add(0, BAD, 6'b0, 0, 4'd1, E_DECILL, M_ALL);
    // illegal funct still writes back
    add(0, RT, 6'b000111, 0, 4'd0, E_FETCH, M_ALL);
    add(0, RT, 6'b000111, 0, 4'd1, E_DEC, M_ALL);
    add(0, RT, 6'b000111, 0, 4'd6, E_EXILL, M_ALL);
    add(0, RT, 6'b000111, 0, 4'd7, E_AWB, M_NOAL);
    // reset held two cycles mid-EXEC
    add(0, RT, 6'b100000, 0, 4'd0, E_FETCH, M_ALL);
    add(0, RT, 6'b100000, 0, 4'd1, E_DEC, M_ALL);
    add(0, RT, 6'b100000, 0, 4'd6, E_EXADD, M_ALL);
    add(1, RT, 6'b100000, 0, 4'd0, E_RST, M_ALL);
    add(1, RT, 6'b100000, 0, 4'd0, E_RST, M_ALL);
    add(0, BEQ, 6'b0, 0, 4'd0, E_FETCH, M_ALL);
    add(0, BEQ, 6'b0, 0, 4'd1, E_DEC, M_ALL);

    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < vq.size(); i++) begin
      reset = vq[i].rst;
      op    = vq[i].op;
      funct = vq[i].fn;
      zero  = vq[i].z;
      #1;
      chk($sformatf("row%0d", i), vq[i].st, vq[i].exp, vq[i].msk);
      @(posedge clk);
      #1;
    end

    // Now in BRANCH: pcen must follow zero within the cycle.
    zero = 1'b0;
    #1;
    chk("br_z0", 4'd8, E_BRZ0, M_ALL);
    zero = 1'b1;
    #1;
    chk("br_z1", 4'd8, E_BRZ1, M_ALL);
    zero = 1'b0;
    #1;
    chk("br_z0b", 4'd8, E_BRZ0, M_ALL);
    @(posedge clk);
    #1;
    chk("br_ret", 4'd0, E_FETCH, M_ALL);

    // Illegal pulse is one cycle wide and the next state is FETCH.
    op = BAD;
    @(posedge clk);
    #1;
    chk("ill_dec", 4'd1, E_DECILL, M_ALL);
    @(posedge clk);
    #1;
    chk("ill_after", 4'd0, E_FETCH, M_ALL);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle MIPS control unit: a Moore state machine, plus a small ALU decoder.
- Sequences the shared datapath (one memory, one ALU) across fetch, decode, execute, memory and writeback cycles.
- Drives every datapath mux select (mux2/mux4 selects) and every register/memory write enable.
- Sits between the instruction register and the datapath.

Parameters:
- STATE_W, 4, width of the state register and of the dbg_state port.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- op  input  6  instr[31:26] from the instruction register
- funct  input  6  instr[5:0] from the instruction register
- zero  input  1  ALU zero flag
- iord  output  1  memory address mux: 0=PC, 1=ALUOut
- alusrca  output  1  ALU A mux: 0=PC, 1=regA
- alusrcb  output  2  ALU B mux: 00=regB, 01=const 4, 10=SignImm, 11=SignImm<<2
- pcsrc  output  2  PC mux: 00=ALUResult, 01=ALUOut, 10=jump target {PC[31:28],instr[25:0],2'b00}
- memtoreg  output  1  writeback data: 0=ALUOut, 1=Data register
- regdst  output  1  write register: 0=rt, 1=rd
- irwrite, memwrite, regwrite  output  1 each  write enables
- pcen  output  1  PC enable = pcwrite | (branch & zero)
- alucontrol  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal  output  1  one-cycle pulse on an unsupported op or funct
- dbg_state  output  STATE_W  current state encoding

Behaviour:
- Reset: synchronous, active-high; the state register reaches FETCH(0) on the first clk edge with reset=1.
- While reset=1, all outputs are forced to 0, including enables, selects and illegal.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 return to FETCH on the next edge with all outputs 0.
- Output assertions per state; any output not listed is 0:
  - FETCH: iord=0, alusrca=0, alusrcb=01, aluop=add, pcsrc=00, irwrite=1, pcwrite=1.
  - DECODE: alusrca=0, alusrcb=11, aluop=add (precomputes the branch target into ALUOut).
  - MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=add.
  - MEMRD: iord=1.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - EXEC: alusrca=1, alusrcb=00, aluop=funct.
  - ALUWB: regdst=1, memtoreg=0, regwrite=1.
  - BRANCH: alusrca=1, alusrcb=00, aluop=sub, pcsrc=01, branch=1.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1.
  - JUMP: pcsrc=10, pcwrite=1.
- Transitions:
  - FETCH->DECODE.
  - DECODE branches on op: 100011 or 101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; any other op -> FETCH with illegal=1 for that DECODE cycle.
  - MEMADR: op=100011 -> MEMRD, else -> MEMWR.
  - MEMRD->MEMWB; EXEC->ALUWB; ADDIEX->ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP all return to FETCH.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- ALU decode:
  - aluop=add gives 010; aluop=sub gives 110.
  - aluop=funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111.
  - Any other funct gives 010 and illegal=1 during EXEC; the FSM still proceeds to ALUWB, so writeback is not suppressed.
- Output timing: all outputs are combinational from the state (plus op/funct/zero). pcen in BRANCH follows zero in the same cycle.
- The FSM has no stall input. Memory is single-cycle.
- Reset mid-instruction: the next state is FETCH and no write enable is asserted during the reset cycle.

Test Plan:
- Reset: hold reset=1 for 2 cycles mid-EXEC. Expect dbg_state=0 and all outputs 0; after release, the FETCH cycle shows irwrite=1, pcen=1, alusrcb=01.
- lw (op=100011): expect the state sequence 0,1,2,3,4,0 and iord=1 only in state 3. regwrite=1 with memtoreg=1 and regdst=0 appear only in state 4.
- R-type (op=000000, funct=101010): states 0,1,6,7,0 with alucontrol=111 in state 6; regwrite=1 and regdst=1 in state 7.
- beq (op=000100): with zero=1, BRANCH shows pcen=1, pcsrc=01, alucontrol=110; with zero=0, pcen=0. Both cases return to FETCH.
- sw (op=101011), then j (op=000010): sw gives states 0,1,2,5 with memwrite=1 only in state 5. j gives states 0,1,11 with pcsrc=10 and pcen=1.
- Illegal cases:
  - op=111111: illegal=1 for one cycle in DECODE, then FETCH, with no write enables asserted.
  - funct=000111: illegal=1 in EXEC and alucontrol=010.
